// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change engine for a 1000/500/100 coin hopper.
// Latches a return amount on i_start and offers one coin at a time, largest
// first, using a valid/ready handshake. Each accepted coin is subtracted from
// the amount still owed. If exact change cannot be completed, o_short is
// raised and the unpaid residue stays visible on o_remaining.
//
// Optional feature (macro CHANGE_DISPENSER_INVENTORY_EN):
//   Keeps a per-denomination inventory counter. A denomination whose counter
//   is zero is skipped. Counters are reloaded to INV_INIT at reset, and by
//   i_refill while IDLE. When the macro is undefined the supply is unlimited
//   and i_refill is ignored.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   i_start         return request (sampled only in IDLE)
//   i_amount        amount to return, latched with i_start
//   i_coin_ready    hopper accepts the offered coin
//   i_refill        reload inventories (inventory build only)
//   o_return_coin   one-hot offered coin: 100=1000, 010=500, 001=100
//   o_coin_valid    o_return_coin holds a valid offer
//   o_busy          not IDLE
//   o_done          one-cycle end-of-request pulse
//   o_short         exact change not possible; held until next i_start
//   o_remaining     amount still owed
module change_dispenser #(
    parameter int unsigned AMOUNT_W  = 32,
    parameter int unsigned INV_W     = 8,
    parameter int unsigned INV_INIT  = 8,
    localparam int unsigned NUM_COINS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [AMOUNT_W-1:0]   i_amount,
    input  logic                  i_coin_ready,
    input  logic                  i_refill,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_coin_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_short,
    output logic [AMOUNT_W-1:0]   o_remaining
);

    localparam logic [NUM_COINS-1:0] COIN_1000 = 3'b100;
    localparam logic [NUM_COINS-1:0] COIN_500  = 3'b010;
    localparam logic [NUM_COINS-1:0] COIN_100  = 3'b001;

    localparam logic [AMOUNT_W-1:0] VAL_1000 = AMOUNT_W'(1000);
    localparam logic [AMOUNT_W-1:0] VAL_500  = AMOUNT_W'(500);
    localparam logic [AMOUNT_W-1:0] VAL_100  = AMOUNT_W'(100);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_OFFER  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_COINS-1:0]   coin_q, coin_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   short_q, short_d;
    logic [AMOUNT_W-1:0]    remaining_q, remaining_d;

    logic [NUM_COINS-1:0]   avail_c;
    logic                   handshake_c;

    // Coin value of a one-hot coin code.
    function automatic logic [AMOUNT_W-1:0] coin_value(input logic [NUM_COINS-1:0] c);
        logic [AMOUNT_W-1:0] v;
        v = '0;
        case (c)
            COIN_1000: v = VAL_1000;
            COIN_500:  v = VAL_500;
            COIN_100:  v = VAL_100;
            default:   v = '0;
        endcase
        return v;
    endfunction

    // A coin is accepted on a ready edge while it is being offered.
    assign handshake_c = (state_q == S_OFFER) && i_coin_ready;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
    logic [NUM_COINS-1:0][INV_W-1:0] inv_q, inv_d;

    // Inventory update: refill only in IDLE, decrement the accepted denomination.
    always_comb begin
        inv_d = inv_q;
        if ((state_q == S_IDLE) && i_refill) begin
            for (int i = 0; i < int'(NUM_COINS); i++) begin
                inv_d[i] = INV_W'(INV_INIT);
            end
        end
        if (handshake_c) begin
            for (int i = 0; i < int'(NUM_COINS); i++) begin
                if (coin_q[i]) begin
                    inv_d[i] = inv_q[i] - INV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_COINS); i++) begin
                inv_q[i] <= INV_W'(INV_INIT);
            end
        end else begin
            inv_q <= inv_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            avail_c[i] = (inv_q[i] != '0);
        end
    end
`else
    logic                  unused_refill;
    logic [INV_W-1:0]      unused_inv_init;

    assign avail_c         = '1;
    assign unused_refill   = i_refill;
    assign unused_inv_init = INV_W'(INV_INIT);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        short_d     = short_q;
        remaining_d = remaining_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    remaining_d = i_amount;
                    short_d     = 1'b0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if ((remaining_q >= VAL_1000) && avail_c[2]) begin
                    coin_d  = COIN_1000;
                    state_d = S_OFFER;
                end else if ((remaining_q >= VAL_500) && avail_c[1]) begin
                    coin_d  = COIN_500;
                    state_d = S_OFFER;
                end else if ((remaining_q >= VAL_100) && avail_c[0]) begin
                    coin_d  = COIN_100;
                    state_d = S_OFFER;
                end else begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_OFFER: begin
                // Selected coin never exceeds remaining, so no underflow.
                if (i_coin_ready) begin
                    remaining_d = remaining_q - coin_value(coin_q);
                    state_d     = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        if (state_d != S_OFFER) begin
            coin_d = '0;
        end
        valid_d = (state_d == S_OFFER);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            coin_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            coin_q      <= coin_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            remaining_q <= remaining_d;
        end
    end

    assign o_return_coin = coin_q;
    assign o_coin_valid  = valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_short       = short_q;
    assign o_remaining   = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. A second instance with INV_INIT=2
// serves the inventory scenario; the observed outputs are muxed by use_inv.
module tb_change_dispenser;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_amount = '0;
    logic          i_coin_ready = 1'b0;
    logic          i_refill = 1'b0;
    logic          use_inv = 1'b0;

    logic [2:0]    m_coin, v_coin;
    logic          m_valid, v_valid, m_busy, v_busy, m_done, v_done, m_short, v_short;
    logic [AW-1:0] m_rem, v_rem;

    wire [2:0]     coin  = use_inv ? v_coin  : m_coin;
    wire           valid = use_inv ? v_valid : m_valid;
    wire           busy  = use_inv ? v_busy  : m_busy;
    wire           done  = use_inv ? v_done  : m_done;
    wire           short = use_inv ? v_short : m_short;
    wire [AW-1:0]  rem   = use_inv ? v_rem   : m_rem;

    change_dispenser #(.AMOUNT_W(AW), .INV_W(8), .INV_INIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_amount(i_amount),
        .i_coin_ready(i_coin_ready), .i_refill(i_refill),
        .o_return_coin(m_coin), .o_coin_valid(m_valid), .o_busy(m_busy),
        .o_done(m_done), .o_short(m_short), .o_remaining(m_rem)
    );

    change_dispenser #(.AMOUNT_W(AW), .INV_W(8), .INV_INIT(2)) dut_inv (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_amount(i_amount),
        .i_coin_ready(i_coin_ready), .i_refill(i_refill),
        .o_return_coin(v_coin), .o_coin_valid(v_valid), .o_busy(v_busy),
        .o_done(v_done), .o_short(v_short), .o_remaining(v_rem)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-request observations filled by run_req.
    logic [31:0] coin_seq;
    int          n_coins, valid_cnt, done_cnt, done_at, first_valid, unstable;
    logic        timed_out;

    task automatic do_reset();
        reset_n = 1'b0; i_start = 1'b0; i_coin_ready = 1'b0; i_refill = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issue one request and follow it to completion. hold=0: ready always 1;
    // hold>0: ready held low for hold offer cycles before each acceptance.
    task automatic run_req(input logic [AW-1:0] amt, input int hold);
        int cyc, wait_cnt;
        logic prev_pend, rdy;
        logic [2:0] prev_coin;
        logic [AW-1:0] prev_rem;
        coin_seq = '0; n_coins = 0; valid_cnt = 0; done_cnt = 0;
        done_at = -1; first_valid = -1; unstable = 0; timed_out = 1'b1;
        cyc = 1; wait_cnt = 0; prev_pend = 1'b0; prev_coin = '0; prev_rem = '0;
        i_start = 1'b1; i_amount = amt; i_coin_ready = (hold == 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        while (cyc < 300) begin
            if (prev_pend && (valid !== 1'b1 || coin !== prev_coin || rem !== prev_rem))
                unstable++;
            rdy = (hold == 0);
            if (valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                valid_cnt++;
                if (hold != 0) begin
                    rdy = (wait_cnt >= hold);
                    wait_cnt = rdy ? 0 : wait_cnt + 1;
                end
                if (rdy) begin
                    coin_seq = {coin_seq[28:0], coin};
                    n_coins++;
                end
            end
            prev_pend = (valid === 1'b1) && !rdy;
            prev_coin = coin; prev_rem = rem;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end else if (done_at >= 0) begin
                timed_out = 1'b0;
                break;
            end
            i_coin_ready = rdy;
            @(posedge clk); #1;
            cyc++;
        end
        i_coin_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({coin, valid, busy, done, short} !== 7'b0) begin errors++;
            $display("FAIL reset_ctrl got %b exp 0000000", {coin, valid, busy, done, short}); end
        checks++; if (rem !== '0) begin errors++;
            $display("FAIL reset_rem got %0d exp 0", rem); end
        do_reset();
    endtask

    task automatic test_change_1800();
        run_req(AW'(1800), 0);
        checks++; if (timed_out) begin errors++; $display("FAIL c1800_timeout got 1 exp 0"); end
        checks++; if (coin_seq !== 32'({3'b100, 3'b010, 3'b001, 3'b001, 3'b001}) || n_coins != 5) begin
            errors++; $display("FAIL c1800_coins got %h/%0d exp %h/5", coin_seq, n_coins,
                               32'({3'b100, 3'b010, 3'b001, 3'b001, 3'b001})); end
        checks++; if (first_valid != 2) begin errors++;
            $display("FAIL c1800_latency got %0d exp 2", first_valid); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL c1800_done got %0d exp 1", done_cnt); end
        checks++; if (rem !== '0 || short !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL c1800_end got rem=%0d short=%b busy=%b exp 0/0/0", rem, short, busy); end
    endtask

    task automatic test_ready_hold();
        run_req(AW'(1000), 4);
        checks++; if (coin_seq !== 32'(3'b100) || n_coins != 1) begin errors++;
            $display("FAIL hold_coins got %h/%0d exp 4/1", coin_seq, n_coins); end
        checks++; if (valid_cnt != 5 || unstable != 0) begin errors++;
            $display("FAIL hold_stable got valid=%0d unstable=%0d exp 5/0", valid_cnt, unstable); end
        checks++; if (rem !== '0 || short !== 1'b0 || done_cnt != 1) begin errors++;
            $display("FAIL hold_end got rem=%0d short=%b done=%0d exp 0/0/1", rem, short, done_cnt); end
    endtask

    task automatic test_short_250();
        run_req(AW'(250), 0);
        checks++; if (coin_seq !== 32'({3'b001, 3'b001}) || n_coins != 2) begin errors++;
            $display("FAIL s250_coins got %h/%0d exp 9/2", coin_seq, n_coins); end
        checks++; if (short !== 1'b1 || rem !== AW'(50) || done_cnt != 1) begin errors++;
            $display("FAIL s250_end got short=%b rem=%0d done=%0d exp 1/50/1", short, rem, done_cnt); end
        repeat (3) @(posedge clk); #1;
        checks++; if (short !== 1'b1) begin errors++;
            $display("FAIL s250_hold got %b exp 1", short); end
    endtask

    task automatic test_zero();
        run_req(AW'(0), 0);
        checks++; if (valid_cnt != 0) begin errors++;
            $display("FAIL zero_valid got %0d exp 0", valid_cnt); end
        checks++; if (done_at != 2 || done_cnt != 1) begin errors++;
            $display("FAIL zero_done got at=%0d cnt=%0d exp 2/1", done_at, done_cnt); end
        checks++; if (short !== 1'b0 || rem !== '0) begin errors++;
            $display("FAIL zero_end got short=%b rem=%0d exp 0/0", short, rem); end
    endtask

    task automatic test_inventory();
        use_inv = 1'b1;
        do_reset();
        run_req(AW'(3500), 0);
`ifdef CHANGE_DISPENSER_INVENTORY_EN
        checks++; if (coin_seq !== 32'({3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001}) || n_coins != 6) begin
            errors++; $display("FAIL inv3500_coins got %h/%0d exp %h/6", coin_seq, n_coins,
                               32'({3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001})); end
        checks++; if (short !== 1'b1 || rem !== AW'(300)) begin errors++;
            $display("FAIL inv3500_end got short=%b rem=%0d exp 1/300", short, rem); end
        run_req(AW'(1000), 0);
        checks++; if (n_coins != 0 || short !== 1'b1 || rem !== AW'(1000)) begin errors++;
            $display("FAIL inv_empty got n=%0d short=%b rem=%0d exp 0/1/1000", n_coins, short, rem); end
        i_refill = 1'b1;
        @(posedge clk); #1;
        i_refill = 1'b0;
`else
        checks++; if (coin_seq !== 32'({3'b100, 3'b100, 3'b100, 3'b010}) || n_coins != 4) begin
            errors++; $display("FAIL u3500_coins got %h/%0d exp %h/4", coin_seq, n_coins,
                               32'({3'b100, 3'b100, 3'b100, 3'b010})); end
        checks++; if (short !== 1'b0 || rem !== '0) begin errors++;
            $display("FAIL u3500_end got short=%b rem=%0d exp 0/0", short, rem); end
`endif
        run_req(AW'(1000), 0);
        checks++; if (coin_seq !== 32'(3'b100) || n_coins != 1 || short !== 1'b0 || rem !== '0) begin
            errors++; $display("FAIL refill_1000 got %h/%0d short=%b rem=%0d exp 4/1/0/0",
                               coin_seq, n_coins, short, rem); end
        use_inv = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        do_reset();
        i_start = 1'b1; i_amount = AW'(1800); i_coin_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            if (valid === 1'b1) n++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (n != 2 || busy !== 1'b1 || rem !== AW'(300)) begin errors++;
            $display("FAIL mid_pre got n=%0d busy=%b rem=%0d exp 2/1/300", n, busy, rem); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({coin, valid, busy, done, short} !== 7'b0 || rem !== '0) begin errors++;
            $display("FAIL mid_async got %b rem=%0d exp 0/0", {coin, valid, busy, done, short}, rem); end
        i_coin_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if ({coin, valid, busy, done} !== 6'b0) begin errors++;
            $display("FAIL mid_held got %b exp 0", {coin, valid, busy, done}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_req(AW'(1000), 0);
        checks++; if (coin_seq !== 32'(3'b100) || n_coins != 1 || first_valid != 2 ||
                      done_cnt != 1 || rem !== '0 || timed_out) begin errors++;
            $display("FAIL mid_restart got %h/%0d fv=%0d done=%0d rem=%0d to=%b exp 4/1/2/1/0/0",
                     coin_seq, n_coins, first_valid, done_cnt, rem, timed_out); end
    endtask

    initial begin
        test_reset();
        test_change_1800();
        test_ready_hold();
        test_short_250();
        test_zero();
        test_inventory();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
